// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the instruction-fetch and data requesters using req/ack handshakes.
// Latency: request sampled in cycle N, m_ce=1 in N+1, requester ack one cycle after m_ack (2 cycles minimum).
// Stall behaviour: stall_req is held while a request is pending. `ARB_TIMEOUT_EN enables the grant-state abort timer and bus_err.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_ce,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_sel,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        stall_req,
  output logic        bus_err
);

  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15 || TIMEOUT < 2) begin : g_param_chk
    $error("mem_port_arbiter: MAX_D_STREAK must be 1..15 and TIMEOUT at least 2");
  end

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t      state_q, state_d;
  logic        m_ce_q, m_ce_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_sel_q, m_sel_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [3:0]  streak_q, streak_d;
  logic        grant_d;
  logic        abort;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          bus_err_q, bus_err_d;

  // Last grant cycle without a memory response forces the abort path.
  assign abort = (state_q != IDLE) && !m_ack && (tmo_q == TW'(TIMEOUT - 1));

  // Timer restarts on every grant entry and counts cycles spent waiting in a grant state.
  always_comb begin
    tmo_d     = '0;
    bus_err_d = abort;
    if (state_q != IDLE) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Timer and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  // Arbitration in IDLE, hold-until-ack in grant states, completion/abort bookkeeping.
  always_comb begin
    state_d    = state_q;
    m_ce_d     = m_ce_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_sel_d    = m_sel_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    streak_d   = streak_q;
    grant_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // While an ack is pulsing the requester still shows its old req, so arbitration waits one cycle.
        if (!if_ack_q && !d_ack_q && (if_req || d_req)) begin
          grant_d = d_req && !(if_req && streak_q == 4'(MAX_D_STREAK));
          m_ce_d  = 1'b1;
          if (grant_d) begin
            state_d   = GNT_D;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_sel_d   = d_sel;
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != 4'(MAX_D_STREAK)) begin
              streak_d = streak_q + 1'b1;
            end
          end else begin
            state_d   = GNT_I;
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
            m_sel_d   = 4'hF;
            streak_d  = '0;
          end
        end
      end
      GNT_I: begin
        if (m_ack || abort) begin
          if_rdata_d = m_ack ? m_rdata : 32'h0;
          if_ack_d   = 1'b1;
          m_ce_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      GNT_D: begin
        if (m_ack || abort) begin
          if (!m_ack) begin
            d_rdata_d = 32'h0;
          end else if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
          d_ack_d = 1'b1;
          m_ce_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        m_ce_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      m_ce_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_sel_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_ce_q     <= m_ce_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_sel_q    <= m_sel_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      streak_q   <= streak_d;
    end
  end

  assign m_ce      = m_ce_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_sel     = m_sel_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign stall_req = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder with wait states, requester tasks and a read-data scoreboard.
// Latency: checks cycle timing of a zero-wait fetch, grant order, hold stability, reset and timeout behaviour.
// Stall behaviour: requesters hold req until ack; responder delays m_ack by a programmable number of cycles.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_ce, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_sel;
  logic [31:0] m_rdata = '0;
  logic        m_ack;
  logic        mdl_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic        stall_req;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] gnt_q[$];
  logic [31:0] last_d_exp = '0;

  bit          mem_on = 1'b1;
  int          wait_cyc = 0;
  int          busy = 0;
  int          last_len = 0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_sel;

  assign m_ack = mdl_ack | stray_ack;

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .stall_req(stall_req), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0010: mem_val = 32'h3401_0020;
      32'h0000_0100: mem_val = 32'hDEAD_BEEF;
      default:       mem_val = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory responder: logs grants, checks the request stays stable, acks after wait_cyc cycles.
  always @(negedge clk) begin
    if (mem_on && m_ce) begin
      if (busy == 0) begin
        cap_we = m_we; cap_addr = m_addr; cap_wdata = m_wdata; cap_sel = m_sel;
        gnt_q.push_back(m_addr);
      end else begin
        check("m_addr_stable", m_addr, cap_addr);
        check("m_wdata_stable", m_wdata, cap_wdata);
        check("m_we_sel_stable", 32'({m_we, m_sel}), 32'({cap_we, cap_sel}));
      end
      if (busy == wait_cyc) begin
        mdl_ack = 1'b1;
        m_rdata = mem_val(m_addr);
        last_len = busy + 1;
        busy = 0;
      end else begin
        mdl_ack = 1'b0;
        busy++;
      end
    end else begin
      mdl_ack = 1'b0;
      busy = 0;
    end
  end

  // Scoreboard: every ack pops the expected read data for that requester.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_ack) begin
        if (if_exp_q.size() == 0) check("if_ack_unexpected", 32'(if_ack), 0);
        else check("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (d_ack) begin
        if (d_exp_q.size() == 0) check("d_ack_unexpected", 32'(d_ack), 0);
        else check("d_rdata", d_rdata, d_exp_q.pop_front());
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    bit got = 1'b0;
    if_req = 1'b1; if_addr = a;
    if_exp_q.push_back(mem_val(a));
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #1;
      got = if_ack;
    end
    if (!got) check("if_ack_timeout", 0, 1);
    if_req = 1'b0;
  endtask

  task automatic dacc(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sel);
    bit got = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_sel = sel;
    if (!we) last_d_exp = mem_val(a);
    d_exp_q.push_back(last_d_exp);
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #1;
      got = d_ack;
    end
    if (!got) check("d_ack_timeout", 0, 1);
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    last_d_exp = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_order[8];
    int          n;
    bit          got;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_ce_we", 32'({m_ce, m_we}), 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_m_sel", 32'(m_sel), 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    check("rst_acks_err_stall", 32'({if_ack, d_ack, bus_err, stall_req}), 0);

    // Zero-wait fetch with cycle-exact timing
    wait_cyc = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    if_exp_q.push_back(mem_val(32'h10));
    @(negedge clk);
    check("f_stall_n", 32'(stall_req), 1);
    check("f_mce_n", 32'(m_ce), 0);
    @(negedge clk);
    check("f_mce_n1", 32'(m_ce), 1);
    check("f_addr_n1", m_addr, 32'h10);
    check("f_we_sel_n1", 32'({m_we, m_sel}), 32'h0F);
    check("f_wdata_n1", m_wdata, 0);
    check("f_stall_n1", 32'(stall_req), 1);
    @(negedge clk);
    check("f_ack_n2", 32'(if_ack), 1);
    check("f_rdata_n2", if_rdata, 32'h3401_0020);
    check("f_stall_n2", 32'(stall_req), 0);
    check("f_mce_n2", 32'(m_ce), 0);
    if_req = 1'b0;
    @(negedge clk);
    check("f_ack_pulse", 32'(if_ack), 0);

    // Simultaneous requests: data wins first
    wait_cyc = 1;
    gnt_q.delete();
    @(posedge clk); #1;
    fork
      fetch(32'h20);
      dacc(1'b0, 32'h100, 32'h0, 4'hF);
    join
    check("sim_gnt_cnt", 32'(gnt_q.size()), 2);
    if (gnt_q.size() == 2) begin
      check("sim_gnt0", gnt_q[0], 32'h100);
      check("sim_gnt1", gnt_q[1], 32'h20);
    end
    check("sim_d_rdata", d_rdata, 32'hDEAD_BEEF);

    // Write with byte enables and 3 wait cycles
    wait_cyc = 3;
    @(posedge clk); #1;
    dacc(1'b1, 32'h200, 32'h1122_3344, 4'b0011);
    check("wr_len", 32'(last_len), 4);
    check("wr_addr", cap_addr, 32'h200);
    check("wr_wdata", cap_wdata, 32'h1122_3344);
    check("wr_we_sel", 32'({cap_we, cap_sel}), 32'h13);
    check("wr_d_rdata_kept", d_rdata, 32'hDEAD_BEEF);

    // Starvation guard: D,D,D,D,I,D,D,I
    wait_cyc = 0;
    gnt_q.delete();
    @(posedge clk); #1;
    fork
      for (int k = 0; k < 6; k++) dacc(1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'hF);
      begin fetch(32'h1000); fetch(32'h1004); end
    join
    exp_order = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h1000, 32'h310, 32'h314, 32'h1004};
    check("stv_gnt_cnt", 32'(gnt_q.size()), 8);
    for (int k = 0; k < 8 && k < gnt_q.size(); k++) check($sformatf("stv_gnt%0d", k), gnt_q[k], exp_order[k]);

    // Reset mid-access followed by a stray m_ack
    wait_cyc = 10;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; d_req = 1'b0; d_exp_q.delete(); last_d_exp = '0;
    mem_on = 1'b0; stray_ack = 1'b1;
    @(negedge clk);
    check("mr_m_ce", 32'(m_ce), 0);
    check("mr_m_addr", m_addr, 0);
    check("mr_d_rdata", d_rdata, 0);
    check("mr_stall", 32'(stall_req), 0);
    @(negedge clk);
    check("mr_m_ce2", 32'(m_ce), 0);
    check("mr_d_ack2", 32'(d_ack), 0);
    @(negedge clk);
    check("mr_d_ack3", 32'(d_ack), 0);
    stray_ack = 1'b0;

    // Timeout: memory never answers
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
`ifdef ARB_TIMEOUT_EN
    if_exp_q.push_back(32'h0);
    n = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (if_ack) got = 1'b1;
      else if (m_ce) n++;
    end
    check("tmo_ack", 32'(got), 1);
    check("tmo_len", 32'(n), 16);
    check("tmo_bus_err", 32'(bus_err), 1);
    check("tmo_m_ce", 32'(m_ce), 0);
    check("tmo_rdata", if_rdata, 0);
    if_req = 1'b0;
    @(negedge clk);
    check("tmo_bus_err_pulse", 32'(bus_err), 0);
`else
    n = 0; got = 1'b0;
    repeat (20) @(negedge clk);
    check("notmo_m_ce", 32'(m_ce), 1);
    check("notmo_bus_err", 32'(bus_err), 0);
    check("notmo_if_ack", 32'(if_ack), 0);
    do_reset();
    if_req = 1'b0;
    if_exp_q.delete();
`endif
    mem_on = 1'b1; wait_cyc = 0;

    // Ordinary fetch after recovery
    @(posedge clk); #1;
    fetch(32'h80);
    repeat (3) @(posedge clk);
    check("end_if_queue_empty", 32'(if_exp_q.size()), 0);
    check("end_d_queue_empty", 32'(d_exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
